// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and the receive FIFO entry type.
// The baud generator derives its divider from the same CLK_HZ/BAUD pair.
`timescale 1ns/1ps
package uart_rx_fifo_pkg;

    // Character width carried by the receiver.
    localparam int UART_DATA_W = 8;

    // Default receive FIFO geometry.
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;

    // System clock and line rate.
    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 9600;

    // One character on the line is start + 8 data + stop.
    localparam int CHAR_BITS  = 10;
    // Timeout fires after this many character times of silence.
    localparam int TOUT_CHARS = 4;

    // 5208 clocks per bit * 10 bits * 4 characters = 208320 clocks.
    localparam int RX_TOUT_CYC = (CLK_HZ / BAUD) * CHAR_BITS * TOUT_CHARS;
    localparam int RX_TOUT_W   = 18;

    // One stored FIFO entry: framing-error flag above the received byte.
    typedef struct packed {
        logic                   ferr;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_mem_dp.sv
// DEPTH x 9 register array for the receive FIFO.
// One synchronous write port, one asynchronous read port; storage has no reset.
`timescale 1ns/1ps
module uart_rx_fifo_mem_dp
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rx_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output rx_entry_t     rdata
);

    rx_entry_t mem [DEPTH];

    // Store the incoming entry on the write strobe; contents persist across reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead read: the addressed entry is visible without a clock.
    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver.
// Circular FIFO of {ferr, byte} entries with show-ahead head output,
// trigger-level and character-timeout interrupts, and a sticky overrun flag.
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int AW         = FIFO_AW,
    parameter int TRIG_LEVEL = 8,
    parameter int TOUT_CYC   = RX_TOUT_CYC,
    parameter int TOUT_W     = RX_TOUT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   wr_ferr,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_ferr,
    input  logic                   fifo_clr,
    input  logic                   ovr_clr,
    output logic                   empty,
    output logic                   full,
    output logic [AW:0]            count,
    output logic                   overrun,
    output logic                   trig_irq,
    output logic                   tout_irq
);

    localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]     CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_TRIG  = (AW+1)'(TRIG_LEVEL);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [TOUT_W-1:0] TOUT_ONE = TOUT_W'(1);
    localparam logic [TOUT_W-1:0] TOUT_MAX = TOUT_W'(TOUT_CYC);
    localparam logic [TOUT_W-1:0] TOUT_PRE = TOUT_W'(TOUT_CYC - 1);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic [TOUT_W-1:0] tout_cnt;
    logic              ovr_q;
    logic              tout_q;

    logic              rd_ok;
    logic              wr_ok;
    logic              wr_drop;
    logic              activity;
    rx_entry_t         wr_entry;
    rx_entry_t         head;

    // Flags come straight from the occupancy count.
    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_FULL);
    assign trig_irq = (cnt >= CNT_TRIG);
    assign count    = cnt;

    // A flush swallows any read or write presented in the same cycle.
    // A read of an empty FIFO is ignored; a read of a full FIFO frees the
    // slot that a simultaneous write then takes.
    assign rd_ok    = rd_en & ~empty & ~fifo_clr;
    assign wr_ok    = wr_en & (~full | rd_ok) & ~fifo_clr;
    assign wr_drop  = wr_en & ~wr_ok & ~fifo_clr;
    assign activity = rd_ok | wr_ok | fifo_clr;

    assign wr_entry.ferr = wr_ferr;
    assign wr_entry.data = wr_data;

    uart_rx_fifo_mem_dp #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Head entry is forced to zero while empty so stale storage never leaks out.
    assign rd_data = empty ? '0   : head.data;
    assign rd_ferr = empty ? 1'b0 : head.ferr;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (fifo_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky overrun: a dropped byte outranks a clear request in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_q <= 1'b0;
        end else if (wr_drop) begin
            ovr_q <= 1'b1;
        end else if (ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

    assign overrun = ovr_q;

    // Character timeout: count idle cycles while data waits, saturate at the limit,
    // and raise the interrupt on the same edge the counter reaches it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tout_cnt <= '0;
            tout_q   <= 1'b0;
        end else if (activity || empty) begin
            tout_cnt <= '0;
            tout_q   <= 1'b0;
        end else if (tout_cnt != TOUT_MAX) begin
            tout_cnt <= tout_cnt + TOUT_ONE;
            if (tout_cnt == TOUT_PRE) begin
                tout_q <= 1'b1;
            end
        end
    end

    assign tout_irq = tout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TRIG  = 8;
    localparam int TOUT  = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_ferr = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_ferr;
    logic        fifo_clr = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overrun;
    logic        trig_irq;
    logic        tout_irq;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_fifo #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .TRIG_LEVEL (TRIG),
        .TOUT_CYC   (TOUT),
        .TOUT_W     (18)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_ferr  (wr_ferr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_ferr  (rd_ferr),
        .fifo_clr (fifo_clr),
        .ovr_clr  (ovr_clr),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overrun  (overrun),
        .trig_irq (trig_irq),
        .tout_irq (tout_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, overrun bit, idle-cycle age.
    logic [8:0] q[$];
    bit         m_ovr = 1'b0;
    int         idle  = 0;
    bit         m_rok;
    bit         m_wok;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_ovr = 1'b0;
            idle  = 0;
        end else begin
            m_rok = rd_en && (q.size() != 0);
            m_wok = wr_en && ((q.size() < DEPTH) || m_rok);
            if (fifo_clr) begin
                q.delete();
                idle = 0;
                if (ovr_clr) m_ovr = 1'b0;
            end else begin
                if (m_rok) void'(q.pop_front());
                if (m_wok) q.push_back({wr_ferr, wr_data});
                if (wr_en && !m_wok) m_ovr = 1'b1;
                else if (ovr_clr)    m_ovr = 1'b0;
                if (m_rok || m_wok) idle = 0;
                else if (idle < TOUT) idle++;
            end
        end
    end

    // Compare all outputs against the model on every falling edge.
    always @(negedge clk) begin
        int sz;
        sz = q.size();
        check("count",    int'(count),    sz);
        check("empty",    int'(empty),    int'(sz == 0));
        check("full",     int'(full),     int'(sz == DEPTH));
        check("trig_irq", int'(trig_irq), int'(sz >= TRIG));
        check("rd_data",  int'(rd_data),  (sz != 0) ? int'(q[0][7:0]) : 0);
        check("rd_ferr",  int'(rd_ferr),  (sz != 0) ? int'(q[0][8])   : 0);
        check("overrun",  int'(overrun),  int'(m_ovr));
        check("tout_irq", int'(tout_irq), int'((sz != 0) && (idle >= TOUT)));
    end

    task automatic step(input bit w, input logic [7:0] d, input bit f,
                        input bit r, input bit c, input bit oc);
        wr_en = w; wr_data = d; wr_ferr = f; rd_en = r; fifo_clr = c; ovr_clr = oc;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; fifo_clr = 1'b0; ovr_clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input bit f);
        step(1'b1, d, f, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_cyc();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) pop();
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        @(posedge clk); #1;
        idle_cyc();
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;

        // Reset mid-stream.
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        #3 reset = 1'b0;
        #1;
        check("rst_empty",   int'(empty),   1);
        check("rst_count",   int'(count),   0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_tout",    int'(tout_irq), 0);
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;

        // Ordering with framing flags.
        push(8'hA5, 1'b0);
        check("ord_data0", int'(rd_data), 8'hA5);
        check("ord_ferr0", int'(rd_ferr), 0);
        push(8'h3C, 1'b1);
        pop();
        check("ord_data1", int'(rd_data), 8'h3C);
        check("ord_ferr1", int'(rd_ferr), 1);
        pop();
        check("ord_empty", int'(empty), 1);

        // Fill, overrun, drain in order, clear overrun.
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        check("fill_full",  int'(full),  1);
        check("fill_count", int'(count), 16);
        push(8'hEE, 1'b1);
        check("ovr_set",   int'(overrun), 1);
        check("ovr_count", int'(count),   16);
        for (int i = 0; i < 16; i++) begin
            check("ovr_pop_data", int'(rd_data), i);
            pop();
        end
        check("ovr_drained", int'(empty), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_clr", int'(overrun), 0);

        // Simultaneous read/write at full and at empty.
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        check("simul_full_count", int'(count),   16);
        check("simul_full_ovr",   int'(overrun), 0);
        check("simul_full_head",  int'(rd_data), 8'h41);
        for (int i = 0; i < 15; i++) pop();
        check("simul_last", int'(rd_data), 8'h55);
        pop();
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        check("simul_empty_count", int'(count), 1);
        check("simul_empty_data",  int'(rd_data), 8'h77);
        pop();

        // Trigger level and pointer wrap.
        for (int i = 0; i < 7; i++) push(8'hC0 + 8'(i), 1'b0);
        check("trig_below", int'(trig_irq), 0);
        push(8'hC7, 1'b0);
        check("trig_at", int'(trig_irq), 1);
        pop();
        check("trig_fall", int'(trig_irq), 0);
        drain();
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            push(b, 1'b0);
            check("wrap_data", int'(rd_data), int'(b));
            pop();
        end

        // Character timeout.
        push(8'h99, 1'b0);
        k = 0;
        while (!tout_irq && k < 300) begin
            idle_cyc();
            k++;
        end
        check("tout_latency", k, TOUT);
        pop();
        check("tout_cleared", int'(tout_irq), 0);
        for (int i = 0; i < TOUT + 20; i++) idle_cyc();
        check("tout_empty", int'(tout_irq), 0);

        // Flush discards a concurrent write; overrun survives it.
        for (int i = 0; i < 17; i++) push(8'h10 + 8'(i), 1'b0);
        step(1'b1, 8'hAB, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clr_count",   int'(count),   0);
        check("clr_overrun", int'(overrun), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 99) < 40), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 4));
            if (i % 700 == 350) begin
                for (int j = 0; j < TOUT + 10; j++) idle_cyc();
            end
        end

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
